// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - core address and data widths shared by the RVFI monitor.
package riscv;
  localparam int PLEN = 34;
  localparam int XLEN = 32;
endpackage

// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - RVFI commit record, end-of-test status encoding and verdict codes.
package rvfi_pkg;
  typedef struct packed {
    logic                       valid;
    logic                       trap;
    logic [4:0]                 rd_addr;
    logic [riscv::PLEN-1:0]     mem_paddr;
    logic [riscv::XLEN/8-1:0]   mem_wmask;
    logic [riscv::XLEN-1:0]     mem_wdata;
  } rvfi_instr_t;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } eot_status_e;

  localparam logic [31:0] EOT_PASS    = 32'h0000_0001;
  localparam logic [31:0] EOT_TIMEOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] EOT_STALL   = 32'hFFFF_FFFE;
endpackage

// File: rtl/rvfi_port_decode.sv
// rtl/rvfi_port_decode.sv - classifies one RVFI commit port as retire, trap or tohost store.
module rvfi_port_decode
  import rvfi_pkg::*;
(
  input  rvfi_instr_t            instr,
  input  logic [riscv::PLEN-1:0] tohost_addr,
  output logic                   retire,
  output logic                   trap,
  output logic                   tohost_hit,
  output logic [31:0]            wdata
);
  assign retire = instr.valid;
  assign trap   = !instr.valid && instr.trap;
  assign wdata  = instr.mem_wdata[31:0];

  // A zero tohost address means detection is disabled.
  assign tohost_hit = instr.valid && (instr.rd_addr == 5'd0) && (|instr.mem_wmask) &&
                      (instr.mem_paddr == tohost_addr) && (|tohost_addr) &&
                      instr.mem_wdata[0];
endmodule

// File: rtl/rvfi_eot_monitor.sv
// rtl/rvfi_eot_monitor.sv - end-of-test monitor: tohost/timeout/stall verdict FSM and counters.
// Define RVFI_EOT_STALL_EN to compile in the retirement-stall watchdog.
module rvfi_eot_monitor
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 2000000,
  parameter int unsigned STALL_CYCLES    = 10000,
  parameter int unsigned CNT_W           = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
  input  logic [riscv::PLEN-1:0]              tohost_addr_i,
  output logic [31:0]                         end_of_test_o,
  output logic                                done_o,
  output logic [2:0]                          status_o,
  output logic [CNT_W-1:0]                    instret_o,
  output logic [CNT_W-1:0]                    trap_cnt_o,
  output logic [31:0]                         cycles_o
);
  logic [NR_COMMIT_PORTS-1:0] retire_vec, trap_vec, hit_vec;
  logic [31:0]                wdata_vec [NR_COMMIT_PORTS];

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_port
    rvfi_port_decode u_dec (
      .instr      (rvfi_i[i]),
      .tohost_addr(tohost_addr_i),
      .retire     (retire_vec[i]),
      .trap       (trap_vec[i]),
      .tohost_hit (hit_vec[i]),
      .wdata      (wdata_vec[i])
    );
  end

  logic             any_hit;
  logic [31:0]      hit_data;
  logic [CNT_W-1:0] ret_inc, trap_inc;

  // Descending scan so the lowest hitting port is the last to assign.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    ret_inc  = '0;
    trap_inc = '0;
    for (int i = NR_COMMIT_PORTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        hit_data = wdata_vec[i];
      end
      ret_inc  = ret_inc + CNT_W'(retire_vec[i]);
      trap_inc = trap_inc + CNT_W'(trap_vec[i]);
    end
  end

  eot_status_e      state_q, next_state;
  logic [31:0]      eot_q, eot_d;
  logic             done_q;
  logic [CNT_W-1:0] instret_q, trap_q;
  logic [31:0]      cycles_q;
  logic             stall_hit;

`ifdef RVFI_EOT_STALL_EN
  localparam int IDLE_W = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALL_CYCLES - 1);
  logic [IDLE_W-1:0] idle_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (|retire_vec)           idle_q <= '0;
      else if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign stall_hit = !(|retire_vec) && (idle_q == IDLE_MAX);
`else
  // Watchdog compiled out: the stall limit is irrelevant here.
  assign stall_hit = 1'b0 & (STALL_CYCLES >= 2);
`endif

  always_comb begin
    next_state = state_q;
    eot_d      = eot_q;
    if (state_q == ST_RUN) begin
      if (any_hit) begin
        next_state = (hit_data == EOT_PASS) ? ST_PASS : ST_FAIL;
        eot_d      = hit_data;
      end else if (cycles_q == 32'(TIMEOUT_CYCLES - 1)) begin
        next_state = ST_TIMEOUT;
        eot_d      = EOT_TIMEOUT;
      end else if (stall_hit) begin
        next_state = ST_STALL;
        eot_d      = EOT_STALL;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      eot_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= next_state;
      eot_q   <= eot_d;
      done_q  <= (next_state != ST_RUN);
    end
  end

  // Counters still take the events of the cycle that leaves RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q <= '0;
      trap_q    <= '0;
      cycles_q  <= '0;
    end else if (state_q == ST_RUN) begin
      instret_q <= instret_q + ret_inc;
      trap_q    <= trap_q + trap_inc;
      if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign end_of_test_o = eot_q;
  assign done_o        = done_q;
  assign status_o      = state_q;
  assign instret_o     = instret_q;
  assign trap_cnt_o    = trap_q;
  assign cycles_o      = cycles_q;
endmodule

// File: tb/tb_rvfi_eot_monitor.sv
// tb/tb_rvfi_eot_monitor.sv - table-driven and sequence checks of rvfi_eot_monitor verdicts and counters.
module tb_rvfi_eot_monitor;
  import rvfi_pkg::*;

  localparam int K_IDLE = 0, K_RET = 1, K_TRAP = 2, K_ST = 3, K_ST_ADDR = 4,
                 K_ST_RD = 5, K_ST_MASK = 6, K_RET_TRAP = 7;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  rvfi_instr_t [1:0]      rvfi;
  logic [riscv::PLEN-1:0] tohost;
  logic [31:0]            eot;
  logic                   done;
  logic [2:0]             status;
  logic [63:0]            instret, trap_cnt;
  logic [31:0]            cycles;

  int n_chk = 0;
  int n_fail = 0;

  rvfi_eot_monitor #(
    .NR_COMMIT_PORTS(2),
    .TIMEOUT_CYCLES (100),
    .STALL_CYCLES   (20),
    .CNT_W          (64)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rvfi_i       (rvfi),
    .tohost_addr_i(tohost),
    .end_of_test_o(eot),
    .done_o       (done),
    .status_o     (status),
    .instret_o    (instret),
    .trap_cnt_o   (trap_cnt),
    .cycles_o     (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k0;
    logic [31:0] d0;
    int          k1;
    logic [31:0] d1;
    eot_status_e st;
    logic [31:0] eot;
    logic [63:0] ir;
    logic [63:0] tr;
  } vec_t;

  vec_t vecs[13];

  function automatic rvfi_instr_t mk(int k, logic [31:0] d);
    rvfi_instr_t r;
    r = '0;
    case (k)
      K_RET:      r.valid = 1'b1;
      K_TRAP:     r.trap = 1'b1;
      K_RET_TRAP: begin r.valid = 1'b1; r.trap = 1'b1; end
      K_ST, K_ST_ADDR, K_ST_RD, K_ST_MASK: begin
        r.valid     = 1'b1;
        r.mem_paddr = tohost;
        r.mem_wmask = '1;
        r.mem_wdata = d;
        if (k == K_ST_ADDR) r.mem_paddr = tohost + 8;
        if (k == K_ST_RD)   r.rd_addr = 5'd5;
        if (k == K_ST_MASK) r.mem_wmask = '0;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(int k0, logic [31:0] d0, int k1, logic [31:0] d1);
    rvfi[0] = mk(k0, d0);
    rvfi[1] = mk(k1, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rvfi = '0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tohost = 'h8000_1000;
    vecs[0]  = '{K_ST,       32'h1,         K_IDLE,  32'h0, ST_PASS, 32'h1,         64'd4, 64'd0};
    vecs[1]  = '{K_ST,       32'h7,         K_ST,    32'h1, ST_FAIL, 32'h7,         64'd5, 64'd0};
    vecs[2]  = '{K_TRAP,     32'h0,         K_ST,    32'h1, ST_PASS, 32'h1,         64'd4, 64'd1};
    vecs[3]  = '{K_ST_RD,    32'h1,         K_RET,   32'h0, ST_RUN,  32'h0,         64'd5, 64'd0};
    vecs[4]  = '{K_ST,       32'h2,         K_IDLE,  32'h0, ST_RUN,  32'h0,         64'd4, 64'd0};
    vecs[5]  = '{K_ST_ADDR,  32'h1,         K_IDLE,  32'h0, ST_RUN,  32'h0,         64'd4, 64'd0};
    vecs[6]  = '{K_ST_MASK,  32'h1,         K_IDLE,  32'h0, ST_RUN,  32'h0,         64'd4, 64'd0};
    vecs[7]  = '{K_RET_TRAP, 32'h0,         K_TRAP,  32'h0, ST_RUN,  32'h0,         64'd4, 64'd1};
    vecs[8]  = '{K_ST,       32'h101,       K_IDLE,  32'h0, ST_FAIL, 32'h101,       64'd4, 64'd0};
    vecs[9]  = '{K_RET,      32'h0,         K_ST,    32'h8000_0001, ST_FAIL, 32'h8000_0001, 64'd5, 64'd0};
    vecs[10] = '{K_IDLE,     32'h0,         K_IDLE,  32'h0, ST_RUN,  32'h0,         64'd3, 64'd0};
    vecs[11] = '{K_TRAP,     32'h0,         K_TRAP,  32'h0, ST_RUN,  32'h0,         64'd3, 64'd2};
    vecs[12] = '{K_ST_RD,    32'h1,         K_ST,    32'h3, ST_FAIL, 32'h3,         64'd5, 64'd0};

    rvfi = '0;
    #1;
    chk("reset_status", 64'(status), 64'(ST_RUN));
    chk("reset_eot", 64'(eot), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_cycles", 64'(cycles), 64'd0);

    // Table: three single-port retirements, then the vector cycle.
    for (int v = 0; v < 13; v++) begin
      do_reset();
      for (int c = 0; c < 3; c++) step(K_RET, 0, K_IDLE, 0);
      step(vecs[v].k0, vecs[v].d0, vecs[v].k1, vecs[v].d1);
      chk($sformatf("v%0d_status", v), 64'(status), 64'(vecs[v].st));
      chk($sformatf("v%0d_eot", v), 64'(eot), 64'(vecs[v].eot));
      chk($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].eot != 0));
      chk($sformatf("v%0d_instret", v), instret, vecs[v].ir);
      chk($sformatf("v%0d_trap", v), trap_cnt, vecs[v].tr);
      chk($sformatf("v%0d_cycles", v), 64'(cycles), 64'd4);
      if (vecs[v].st != ST_RUN) begin
        step(K_RET, 0, K_RET, 0);
        chk($sformatf("v%0d_frozen_instret", v), instret, vecs[v].ir);
        chk($sformatf("v%0d_frozen_eot", v), 64'(eot), 64'(vecs[v].eot));
      end
    end

    // PASS from port 1 at cycle 50.
    do_reset();
    for (int c = 1; c < 50; c++) step(K_RET, 0, K_IDLE, 0);
    chk("pass50_done_before", 64'(done), 64'd0);
    chk("pass50_cycles_before", 64'(cycles), 64'd49);
    step(K_RET, 0, K_ST, 32'h1);
    chk("pass50_status", 64'(status), 64'(ST_PASS));
    chk("pass50_eot", 64'(eot), 64'h1);
    chk("pass50_done", 64'(done), 64'd1);
    chk("pass50_instret", instret, 64'd51);
    for (int c = 0; c < 5; c++) step(K_RET, 0, K_RET, 0);
    chk("pass50_frozen_instret", instret, 64'd51);
    chk("pass50_frozen_cycles", 64'(cycles), 64'd50);
    chk("pass50_done_hold", 64'(done), 64'd1);

    // Timeout at 100 cycles under continuous retirement.
    do_reset();
    for (int c = 1; c < 100; c++) step(K_RET, 0, K_RET, 0);
    chk("tmo_status_99", 64'(status), 64'(ST_RUN));
    chk("tmo_cycles_99", 64'(cycles), 64'd99);
    step(K_RET, 0, K_RET, 0);
    chk("tmo_status", 64'(status), 64'(ST_TIMEOUT));
    chk("tmo_eot", 64'(eot), 64'hFFFF_FFFF);
    chk("tmo_cycles", 64'(cycles), 64'd100);
    chk("tmo_instret", instret, 64'd200);
    for (int c = 0; c < 10; c++) step(K_RET, 0, K_RET, 0);
    chk("tmo_frozen_cycles", 64'(cycles), 64'd100);
    chk("tmo_frozen_instret", instret, 64'd200);

    // Retirement ends at cycle 30, traps continue.
    do_reset();
    for (int c = 1; c <= 30; c++) step(K_RET, 0, K_IDLE, 0);
    for (int c = 31; c < 50; c++) step(K_IDLE, 0, K_TRAP, 0);
    chk("stall_status_49", 64'(status), 64'(ST_RUN));
    chk("stall_trap_49", trap_cnt, 64'd19);
    step(K_IDLE, 0, K_TRAP, 0);
`ifdef RVFI_EOT_STALL_EN
    chk("stall_status", 64'(status), 64'(ST_STALL));
    chk("stall_eot", 64'(eot), 64'hFFFF_FFFE);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_trap", trap_cnt, 64'd20);
`else
    for (int c = 51; c <= 60; c++) step(K_IDLE, 0, K_TRAP, 0);
    chk("nostall_status", 64'(status), 64'(ST_RUN));
    chk("nostall_eot", 64'(eot), 64'd0);
    chk("nostall_done", 64'(done), 64'd0);
    chk("nostall_trap", trap_cnt, 64'd30);
`endif
    chk("stall_instret", instret, 64'd30);

    // Two ports for 10 cycles then one trap; then tohost disabled.
    do_reset();
    for (int c = 0; c < 10; c++) step(K_RET, 0, K_RET, 0);
    step(K_TRAP, 0, K_IDLE, 0);
    chk("cnt_instret", instret, 64'd20);
    chk("cnt_trap", trap_cnt, 64'd1);
    tohost = '0;
    step(K_ST, 32'h1, K_ST, 32'h1);
    step(K_IDLE, 0, K_IDLE, 0);
    chk("tohost0_status", 64'(status), 64'(ST_RUN));
    chk("tohost0_eot", 64'(eot), 64'd0);
    chk("tohost0_instret", instret, 64'd22);
    tohost = 'h8000_1000;

    // Reset mid-run, then PASS at cycle 10 after release.
    do_reset();
    for (int c = 1; c < 40; c++) step(K_RET, 0, K_RET, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_cycles", 64'(cycles), 64'd0);
    chk("midrst_status", 64'(status), 64'(ST_RUN));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c < 10; c++) step(K_RET, 0, K_IDLE, 0);
    step(K_IDLE, 0, K_ST, 32'h1);
    chk("midrst_pass_status", 64'(status), 64'(ST_PASS));
    chk("midrst_pass_eot", 64'(eot), 64'h1);
    chk("midrst_pass_instret", instret, 64'd10);
    chk("midrst_pass_cycles", 64'(cycles), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
